fir_controller: RTL and testbench



---
 rtl/fir_controller.sv | 90 +++++++++
 tb/tb_fir_controller.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fir_controller.sv
// rtl/fir_controller.sv - FIR datapath control FSM: sample handshake, tap sweep, pipe drain, result flag.
module fir_controller #(
  parameter int FIR_size  = 64,
  parameter int AddrWidth = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 input_valid,
  output logic                 input_ready,
  output logic                 shift,
  output logic                 flush,
  output logic                 freeze,
  output logic [AddrWidth-1:0] address,
  output logic                 output_valid
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DRAIN,
    DONE
  } state_t;

  localparam logic [AddrWidth-1:0] LastTap = AddrWidth'(FIR_size - 1);

  state_t               state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (input_valid) state_d = CALC;
      end
      CALC: begin
        // Stop on the last tap rather than relying on counter wrap.
        if (cnt_q == LastTap) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced safe while rst is high; shift/flush follow input_valid in IDLE.
  always_comb begin
    input_ready  = 1'b0;
    shift        = 1'b0;
    flush        = 1'b0;
    freeze       = 1'b1;
    address      = '0;
    output_valid = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          input_ready = 1'b1;
          shift       = input_valid;
          flush       = input_valid;
        end
        CALC: begin
          freeze  = 1'b0;
          address = cnt_q;
        end
        DONE:    output_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_controller.sv
// tb/tb_fir_controller.sv - directed bench for fir_controller with a behavioural FIR datapath alongside.
module tb_fir_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       input_valid;
  logic       input_ready, shift, flush, freeze, output_valid;
  logic [5:0] address;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_controller #(.FIR_size(64), .AddrWidth(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .input_valid (input_valid),
    .input_ready (input_ready),
    .shift       (shift),
    .flush       (flush),
    .freeze      (freeze),
    .address     (address),
    .output_valid(output_valid)
  );

  // Behavioural datapath following the controller's timing contract.
  logic signed [15:0] din;
  logic signed [15:0] coef [64];
  logic signed [15:0] sr   [64];
  logic signed [31:0] pipe_q;
  logic signed [37:0] acc_q;

  always @(posedge clk) begin
    if (shift) begin
      for (int i = 63; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= din;
    end
    if (flush || freeze) pipe_q <= '0;
    else                 pipe_q <= sr[address] * coef[address];
    if (flush) acc_q <= '0;
    else       acc_q <= acc_q + {{6{pipe_q[31]}}, pipe_q};
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive input_valid, sample outputs at the falling edge.
  // o = {input_ready, shift, flush, freeze, output_valid, address[5:0]}
  task automatic cyc(input logic v, output logic [10:0] o);
    input_valid = v;
    @(negedge clk);
    o = {input_ready, shift, flush, freeze, output_valid, address};
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] exp_seq(input int c);
    logic [10:0] e;
    e[10]  = (c == 0) || (c == 67);
    e[9]   = (c == 0);
    e[8]   = (c == 0);
    e[7]   = !((c >= 1) && (c <= 64));
    e[6]   = (c == 66);
    e[5:0] = ((c >= 1) && (c <= 64)) ? 6'(c - 1) : 6'd0;
    return e;
  endfunction

  task automatic run_seq(input string tag);
    logic [10:0] o;
    for (int c = 0; c <= 67; c++) begin
      cyc(c == 0, o);
      check($sformatf("%s_c%0d", tag, c), o, exp_seq(c));
    end
  endtask

  // Present one sample, wait (bounded) for output_valid, return dout.
  task automatic sample(input logic signed [15:0] d, output longint res);
    logic [10:0] o;
    int n;
    din = d;
    cyc(1'b1, o);
    n = 0;
    do begin
      cyc(1'b0, o);
      n++;
    end while (!o[6] && n < 100);
    if (!o[6]) check("ov_timeout", o[6], 1);
    res = longint'(acc_q);
  endtask

  initial begin
    logic [10:0] o;
    longint      r;
    int          nshift, last;

    din         = '0;
    input_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      sr[i]   = '0;
      coef[i] = 16'sd1;
    end
    pipe_q = '0;
    acc_q  = '0;

    // Reset with a sample presented: must not be accepted.
    rst = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      cyc(1'b1, o);
      check($sformatf("rst_c%0d", c), o, 11'b000_1000_0000);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b0, o);
      check($sformatf("idle_c%0d", c), o, 11'b100_1000_0000);
    end

    run_seq("single");

    // Mid-CALC reset at address 30.
    cyc(1'b1, o);
    for (int c = 1; c <= 30; c++) cyc(1'b0, o);
    check("mid_addr29", o[5:0], 29);
    rst = 1'b1;
    cyc(1'b0, o);
    check("mid_rst_out", o, 11'b000_1000_0000);
    rst = 1'b0;
    for (int c = 0; c < 70; c++) begin
      cyc(1'b0, o);
      check($sformatf("mid_idle_c%0d", c), o, 11'b100_1000_0000);
    end
    run_seq("post_rst");

    // Back-pressure: input_valid held continuously.
    nshift = 0;
    last   = 0;
    for (int c = 0; c < 206; c++) begin
      cyc(1'b1, o);
      check("bp_shift_gate", o[9] & ~o[10], 0);
      if (o[9]) begin
        if (nshift > 0) check($sformatf("bp_gap_%0d", nshift), c - last, 67);
        last = c;
        nshift++;
      end
    end
    check("bp_count", nshift, 4);
    for (int c = 0; c < 70 && !o[10]; c++) cyc(1'b0, o);
    check("bp_back_idle", o[10], 1);

    // Impulse through the datapath, unit coefficients.
    sample(16'sd5, r);
    check("imp_1", r, 5);
    for (int k = 2; k <= 64; k++) begin
      sample(16'sd0, r);
      check($sformatf("imp_%0d", k), r, 5);
    end
    sample(16'sd0, r);
    check("imp_65", r, 0);

    // Full-scale negative samples against max positive coefficients.
    for (int i = 0; i < 64; i++) coef[i] = 16'sh7FFF;
    sample(16'sh8000, r);
    check("wide_1", r, -64'sd1073709056);
    for (int k = 2; k <= 64; k++) sample(16'sh8000, r);
    check("wide_64", r, -64'sd68717379584);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
